// File: rtl/register_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | register_file: RISC-V integer register file, 2 async reads, 1 sync write |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_reg,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_reg_1,
   input  logic [ADDR_WIDTH-1:0] rd_reg_2,
   output logic [DATA_WIDTH-1:0] rd_data_1,
   output logic [DATA_WIDTH-1:0] rd_data_2
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic                  wr_accept;

   // x0 is never written, so its storage stays at the reset value of zero.
   assign wr_accept = wr_en && (wr_reg != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_accept) begin
         regs[wr_reg] <= wr_data;
      end
   end

   // Reads are unregistered and deliberately not bypassed from the write port.
   always_comb begin
      rd_data_1 = '0;
      rd_data_2 = '0;
      if (rd_reg_1 != '0) rd_data_1 = regs[rd_reg_1];
      if (rd_reg_2 != '0) rd_data_2 = regs[rd_reg_2];
   end

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_register_file: randomized self-checking bench for register_file       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_register_file;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [4:0]  wr_reg;
   logic [31:0] wr_data;
   logic [4:0]  rd_reg_1;
   logic [4:0]  rd_reg_2;
   logic [31:0] rd_data_1;
   logic [31:0] rd_data_2;

   logic [31:0] model [32];
   int          vectors;
   int          miscompares;

   register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_reg    (wr_reg),
      .wr_data   (wr_data),
      .rd_reg_1  (rd_reg_1),
      .rd_reg_2  (rd_reg_2),
      .rd_data_1 (rd_data_1),
      .rd_data_2 (rd_data_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   // One write cycle: drive at negedge, let the edge pass, then update the model.
   task automatic cycle_write(input logic en, input logic [4:0] r, input logic [31:0] d);
      @(negedge clk);
      wr_en = en; wr_reg = r; wr_data = d;
      @(posedge clk);
      #1;
      if (en && rst_n && r != 5'd0) model[r] = d;
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] idx;
      rst_n = 1'b0; wr_en = 1'b0; wr_reg = '0; wr_data = '0;
      rd_reg_1 = 5'd0; rd_reg_2 = 5'd0;
      model_clear();
      #2;
      vectors++;
      if (rd_data_1 !== 32'h0 || rd_data_2 !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_x0 got %h/%h want 0/0", rd_data_1, rd_data_2);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idx = 5'($urandom_range(1, 31));
      rd_reg_1 = idx; rd_reg_2 = idx;
      #1;
      vectors++;
      if (rd_data_1 !== 32'h0 || rd_data_2 !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_rand x%0d got %h/%h want 0/0", idx, rd_data_1, rd_data_2);
      end
   endtask

   task automatic test_write_read();
      cycle_write(1'b1, 5'd5, 32'hDEADBEEF);
      rd_reg_1 = 5'd5; rd_reg_2 = 5'd0;
      #1;
      vectors++;
      if (rd_data_1 !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL write_x5 got %h want deadbeef", rd_data_1);
      end
      vectors++;
      if (rd_data_2 !== 32'h0) begin
         miscompares++;
         $display("FAIL read_x0 got %h want 0", rd_data_2);
      end
   endtask

   task automatic test_overwrite();
      cycle_write(1'b1, 5'd15, 32'hFFFF0000);
      cycle_write(1'b1, 5'd15, 32'h0000FFFF);
      rd_reg_1 = 5'd5; rd_reg_2 = 5'd15;
      #1;
      vectors++;
      if (rd_data_1 !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL overwrite_x5 got %h want deadbeef", rd_data_1);
      end
      vectors++;
      if (rd_data_2 !== 32'h0000FFFF) begin
         miscompares++;
         $display("FAIL overwrite_x15 got %h want 0000ffff", rd_data_2);
      end
   endtask

   task automatic test_idle();
      cycle_write(1'b0, 5'd15, 32'h12345678);
      rd_reg_1 = 5'd15; rd_reg_2 = 5'd5;
      #1;
      vectors++;
      if (rd_data_1 !== 32'h0000FFFF || rd_data_2 !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL idle_hold got %h/%h want 0000ffff/deadbeef", rd_data_1, rd_data_2);
      end
   endtask

   task automatic test_x0_write();
      cycle_write(1'b1, 5'd0, 32'hFFFFFFFF);
      rd_reg_1 = 5'd0; rd_reg_2 = 5'd0;
      #1;
      vectors++;
      if (rd_data_1 !== 32'h0 || rd_data_2 !== 32'h0) begin
         miscompares++;
         $display("FAIL x0_write got %h/%h want 0/0", rd_data_1, rd_data_2);
      end
   endtask

   task automatic test_read_during_write();
      // Before the edge the old value must be visible; after it, the new one.
      @(negedge clk);
      wr_en = 1'b1; wr_reg = 5'd5; wr_data = 32'hCAFEF00D;
      rd_reg_1 = 5'd5; rd_reg_2 = 5'd5;
      #1;
      vectors++;
      if (rd_data_1 !== model[5] || rd_data_2 !== model[5]) begin
         miscompares++;
         $display("FAIL rdw_old got %h/%h want %h", rd_data_1, rd_data_2, model[5]);
      end
      @(posedge clk);
      #1;
      model[5] = 32'hCAFEF00D;
      wr_en = 1'b0;
      vectors++;
      if (rd_data_1 !== 32'hCAFEF00D || rd_data_2 !== 32'hCAFEF00D) begin
         miscompares++;
         $display("FAIL rdw_new got %h/%h want cafef00d", rd_data_1, rd_data_2);
      end
   endtask

   task automatic test_async_reset();
      cycle_write(1'b1, 5'd9, 32'hA5A5A5A5);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      model_clear();
      rd_reg_1 = 5'd5; rd_reg_2 = 5'd9;
      #1;
      vectors++;
      if (rd_data_1 !== 32'h0 || rd_data_2 !== 32'h0) begin
         miscompares++;
         $display("FAIL async_reset got %h/%h want 0/0", rd_data_1, rd_data_2);
      end
      // A write presented while reset is held must be dropped.
      @(negedge clk);
      wr_en = 1'b1; wr_reg = 5'd7; wr_data = 32'h77777777;
      @(posedge clk);
      #1;
      rd_reg_1 = 5'd7;
      #1;
      vectors++;
      if (rd_data_1 !== 32'h0) begin
         miscompares++;
         $display("FAIL write_in_reset got %h want 0", rd_data_1);
      end
      @(negedge clk);
      wr_en = 1'b0;
      rst_n = 1'b1;
      cycle_write(1'b1, 5'd7, 32'h13572468);
      rd_reg_1 = 5'd7; rd_reg_2 = 5'd15;
      #1;
      vectors++;
      if (rd_data_1 !== 32'h13572468 || rd_data_2 !== 32'h0) begin
         miscompares++;
         $display("FAIL first_write_after_reset got %h/%h want 13572468/0", rd_data_1, rd_data_2);
      end
   endtask

   task automatic test_random();
      logic        en;
      logic [4:0]  r;
      logic [31:0] d;
      for (int n = 0; n < 10000; n++) begin
         @(negedge clk);
         en = 1'($urandom_range(0, 1));
         r  = 5'($urandom_range(0, 31));
         d  = $urandom;
         wr_en = en; wr_reg = r; wr_data = d;
         rd_reg_1 = (n % 4 == 0) ? r : 5'($urandom_range(0, 31));
         rd_reg_2 = 5'($urandom_range(0, 31));
         #1;
         vectors++;
         if (rd_data_1 !== model[rd_reg_1]) begin
            miscompares++;
            $display("FAIL rand_rd1 cyc %0d x%0d got %h want %h", n, rd_reg_1, rd_data_1, model[rd_reg_1]);
         end
         vectors++;
         if (rd_data_2 !== model[rd_reg_2]) begin
            miscompares++;
            $display("FAIL rand_rd2 cyc %0d x%0d got %h want %h", n, rd_reg_2, rd_data_2, model[rd_reg_2]);
         end
         @(posedge clk);
         if (en && r != 5'd0) model[r] = d;
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_write_read();
      test_overwrite();
      test_idle();
      test_x0_write();
      test_read_during_write();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
